// File: rtl/pipeline_debug_ctrl.sv
// UART-driven run/step/pause/clear sequencer for the pipeline, dumping a cycle-count + debug-word snapshot after every stop.
// Optional macro DBG_CHKSUM_EN appends an XOR checksum byte to each dump.
module pipeline_debug_ctrl #(
    parameter int NUM_WORDS = 4,
    parameter int SEL_W     = 3
) (
    input  logic             clk100,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    input  logic             halt_in,
    output logic             pipe_en,
    output logic             pipe_rst,
    output logic [SEL_W-1:0] dbg_sel,
    input  logic [31:0]      dbg_word,
    output logic [1:0]       mode,
    output logic [2:0]       dbg_state
);

    // Handshakes: rx_valid is a one-cycle strobe qualifying rx_data; tx_start pulses only
    // while tx_busy is low, and tx_busy is ignored for one guard cycle after it because
    // the transmitter raises busy one cycle late. tx_data stays put until the next byte.
    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_STEP, S_LOAD, S_SEND, S_GUARD, S_WAIT
    } state_t;

    localparam logic [SEL_W:0] LAST_WORD = (SEL_W+1)'(NUM_WORDS);

    state_t           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [SEL_W:0]   word_idx_q, word_idx_d;
    logic [SEL_W-1:0] dbg_sel_q, dbg_sel_d;
    logic             load_wait_q, load_wait_d;
    logic             pipe_rst_q, pipe_rst_d;
`ifdef DBG_CHKSUM_EN
    logic [7:0]       chk_q, chk_d;
    logic             chk_phase_q, chk_phase_d;
`endif

    logic cmd_r, cmd_s, cmd_p, cmd_c;
    assign cmd_r = rx_valid && (rx_data == 8'h52);
    assign cmd_s = rx_valid && (rx_data == 8'h53);
    assign cmd_p = rx_valid && (rx_data == 8'h50);
    assign cmd_c = rx_valid && (rx_data == 8'h43);

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_of = w[31:24];
            2'd1:    byte_of = w[23:16];
            2'd2:    byte_of = w[15:8];
            default: byte_of = w[7:0];
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        tx_data_d   = tx_data_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        dbg_sel_d   = dbg_sel_q;
        load_wait_d = load_wait_q;
        pipe_rst_d  = 1'b0;
        tx_start    = 1'b0;
`ifdef DBG_CHKSUM_EN
        chk_d       = chk_q;
        chk_phase_d = chk_phase_q;
`endif
        pipe_en = (state_q == S_RUN) || (state_q == S_STEP);
        if (pipe_en) cnt_d = cnt_q + 32'd1;

        case (state_q)
            S_IDLE, S_RUN, S_STEP: begin
                if (cmd_c) begin
                    pipe_rst_d = 1'b1;
                    cnt_d      = 32'd0;
                    state_d    = S_IDLE;
                end else if ((state_q == S_IDLE && !halt_in && cmd_r)) begin
                    state_d = S_RUN;
                end else if ((state_q == S_IDLE && !halt_in && cmd_s)) begin
                    state_d = S_STEP;
                end else if (state_q == S_STEP ||
                             (state_q == S_RUN && (cmd_p || halt_in))) begin
                    state_d     = S_LOAD;
                    word_idx_d  = '0;
                    dbg_sel_d   = '0;
                    load_wait_d = 1'b0;
`ifdef DBG_CHKSUM_EN
                    chk_d       = 8'd0;
                    chk_phase_d = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                // First cycle lets dbg_word settle on the new select; second latches it.
                if (!load_wait_q) begin
                    load_wait_d = 1'b1;
                end else begin
                    load_wait_d = 1'b0;
                    word_d      = (word_idx_q == '0) ? cnt_q : dbg_word;
                    tx_data_d   = byte_of(word_d, 2'd0);
                    byte_idx_d  = 2'd0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = S_GUARD;
`ifdef DBG_CHKSUM_EN
                    chk_d    = chk_q ^ tx_data_q;
`endif
                end
            end
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (!tx_busy) begin
`ifdef DBG_CHKSUM_EN
                    if (chk_phase_q) begin
                        state_d   = S_IDLE;
                        dbg_sel_d = '0;
                    end else
`endif
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_data_d  = byte_of(word_q, byte_idx_d);
                        state_d    = S_SEND;
                    end else if (word_idx_q != LAST_WORD) begin
                        // Dump word k (k>=1) reads debug select k-1.
                        word_idx_d = word_idx_q + 1'b1;
                        dbg_sel_d  = word_idx_q[SEL_W-1:0];
                        state_d    = S_LOAD;
                    end else begin
`ifdef DBG_CHKSUM_EN
                        chk_phase_d = 1'b1;
                        tx_data_d   = chk_q;
                        state_d     = S_SEND;
`else
                        state_d   = S_IDLE;
                        dbg_sel_d = '0;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            word_q      <= 32'd0;
            tx_data_q   <= 8'd0;
            byte_idx_q  <= 2'd0;
            word_idx_q  <= '0;
            dbg_sel_q   <= '0;
            load_wait_q <= 1'b0;
            pipe_rst_q  <= 1'b0;
`ifdef DBG_CHKSUM_EN
            chk_q       <= 8'd0;
            chk_phase_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            tx_data_q   <= tx_data_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            dbg_sel_q   <= dbg_sel_d;
            load_wait_q <= load_wait_d;
            pipe_rst_q  <= pipe_rst_d;
`ifdef DBG_CHKSUM_EN
            chk_q       <= chk_d;
            chk_phase_q <= chk_phase_d;
`endif
        end
    end

    always_comb begin
        case (state_q)
            S_IDLE:        mode = halt_in ? 2'd3 : 2'd0;
            S_RUN, S_STEP: mode = 2'd1;
            default:       mode = 2'd2;
        endcase
    end

    assign tx_data   = tx_data_q;
    assign dbg_sel   = dbg_sel_q;
    assign pipe_rst  = pipe_rst_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Bench for pipeline_debug_ctrl: predicted dump bytes go into a queue, a tx monitor pops and compares.
module tb_pipeline_debug_ctrl;
  localparam int NUM_WORDS = 4;
  localparam int SEL_W = 3;

  logic clk100, rst_n;
  logic [7:0] rx_data;
  logic rx_valid;
  logic [7:0] tx_data;
  logic tx_start, tx_busy, halt_in, pipe_en, pipe_rst;
  logic [SEL_W-1:0] dbg_sel;
  logic [31:0] dbg_word;
  logic [1:0] mode;
  logic [2:0] dbg_state;

  pipeline_debug_ctrl #(.NUM_WORDS(NUM_WORDS), .SEL_W(SEL_W)) dut (
    .clk100(clk100), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .halt_in(halt_in),
    .pipe_en(pipe_en), .pipe_rst(pipe_rst), .dbg_sel(dbg_sel), .dbg_word(dbg_word),
    .mode(mode), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  int cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  // pipeline-side debug word memory with one-cycle read latency
  logic [31:0] dbg_mem [0:(1<<SEL_W)-1];
  always @(posedge clk100) dbg_word <= dbg_mem[dbg_sel];

  // scoreboard state
  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int pe_obs = 0;
  int starts = 0;
  int rst_pulses = 0;
  logic prev_rst = 1'b0;
  logic start_pending = 1'b0;
  int busy_len = 2;
  int busy_cnt = 0;
  logic [31:0] cnt_model = 32'd0;
  logic [7:0] exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // monitor: tx bytes, pipe_en cycles, pipe_rst pulse width
  always @(negedge clk100) begin
    if (rst_n) begin
      if (pipe_en) pe_obs++;
      if (pipe_rst) begin
        rst_pulses++;
        check("pipe_rst_width", {31'd0, prev_rst}, 32'd0);
      end
      prev_rst = pipe_rst;
      if (tx_start) begin
        starts++;
        start_pending = 1'b1;
        check("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_tx_start actual=0x%0h required=none", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            failures++;
            $display("FAIL tx_byte actual=0x%0h required=0x%0h", tx_data, exp_b);
          end
        end
      end
    end else begin
      prev_rst = 1'b0;
    end
  end

  // UART transmitter model: busy rises the cycle after tx_start, for busy_len cycles
  always @(posedge clk100) begin
    #1;
    if (start_pending) begin
      start_pending = 1'b0;
      busy_cnt = busy_len;
      tx_busy = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  // driver tasks
  task automatic send_cmd(input logic [7:0] b, output int at);
    @(negedge clk100);
    at = cyc;
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk100);
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic push_dump();
    logic [31:0] w;
    logic [7:0] b;
`ifdef DBG_CHKSUM_EN
    logic [7:0] x;
    x = 8'd0;
`endif
    for (int k = 0; k <= NUM_WORDS; k++) begin
      w = (k == 0) ? cnt_model : dbg_mem[k-1];
      for (int j = 3; j >= 0; j--) begin
        b = w[8*j +: 8];
        exp_q.push_back(b);
`ifdef DBG_CHKSUM_EN
        x = x ^ b;
`endif
      end
    end
`ifdef DBG_CHKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mode == 2'd2) && n < 4000) begin
      @(negedge clk100);
      n++;
    end
    check(name, {31'd0, (n >= 4000)}, 32'd0);
  endtask

  task automatic wait_dump_start(input string name);
    int n;
    n = 0;
    while (mode != 2'd2 && n < 100) begin
      @(negedge clk100);
      n++;
    end
    check(name, {31'd0, (n >= 100)}, 32'd0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < (1 << SEL_W); i++) dbg_mem[i] = $urandom;
  endtask

  int a, b, pe0, st0, rp0, len, n;

  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_busy = 1'b0;
    halt_in = 1'b0;
    for (int i = 0; i < (1 << SEL_W); i++) dbg_mem[i] = 32'h11223344;
    repeat (3) @(negedge clk100);
    check("reset_pipe_en", {31'd0, pipe_en}, 32'd0);
    check("reset_pipe_rst", {31'd0, pipe_rst}, 32'd0);
    check("reset_tx_start", {31'd0, tx_start}, 32'd0);
    check("reset_tx_data", {24'd0, tx_data}, 32'd0);
    check("reset_dbg_sel", {29'd0, dbg_sel}, 32'd0);
    check("reset_mode", {30'd0, mode}, 32'd0);
    rst_n = 1'b1;

    // single step with constant debug words
    pe0 = pe_obs;
    cnt_model = cnt_model + 32'd1;
    push_dump();
    send_cmd(8'h53, a);
    wait_idle("step_dump_done");
    check("step_pipe_en_cycles", pe_obs - pe0, 32'd1);
    check("step_mode_after", {30'd0, mode}, 32'd0);
    check("step_dbg_sel_after", {29'd0, dbg_sel}, 32'd0);

    // run ~100 cycles then pause
    randomize_mem();
    busy_len = 3;
    pe0 = pe_obs;
    send_cmd(8'h52, a);
    repeat (100) @(negedge clk100);
    send_cmd(8'h50, b);
    cnt_model = cnt_model + 32'(b - a);
    push_dump();
    check("run_pause_pipe_en_cycles", pe_obs - pe0, 32'(b - a));
    pe0 = pe_obs;
    wait_idle("pause_dump_done");
    check("pipe_en_low_after_pause", pe_obs - pe0, 32'd0);

    // run then halt; halted-idle ignores R and S
    randomize_mem();
    busy_len = $urandom_range(1, 6);
    send_cmd(8'h52, a);
    repeat (50) @(negedge clk100);
    b = cyc;
    halt_in = 1'b1;
    cnt_model = cnt_model + 32'(b - a);
    push_dump();
    wait_idle("halt_dump_done");
    check("halt_mode", {30'd0, mode}, 32'd3);
    pe0 = pe_obs;
    st0 = starts;
    send_cmd(8'h52, a);
    send_cmd(8'h53, a);
    repeat (40) @(negedge clk100);
    check("halted_no_pipe_en", pe_obs - pe0, 32'd0);
    check("halted_no_tx_start", starts - st0, 32'd0);
    check("halted_mode_held", {30'd0, mode}, 32'd3);
    @(negedge clk100);
    halt_in = 1'b0;

    // C and R during a slow dump are dropped; C afterwards clears the counter
    randomize_mem();
    busy_len = 30;
    rp0 = rst_pulses;
    pe0 = pe_obs;
    cnt_model = cnt_model + 32'd1;
    push_dump();
    send_cmd(8'h53, a);
    wait_dump_start("dump_started");
    repeat (20) @(negedge clk100);
    send_cmd(8'h43, a);
    send_cmd(8'h52, a);
    wait_idle("dump_with_drops_done");
    check("dropped_c_no_pipe_rst", rst_pulses - rp0, 32'd0);
    check("dropped_r_no_run", pe_obs - pe0, 32'd1);
    send_cmd(8'h43, a);
    cnt_model = 32'd0;
    repeat (3) @(negedge clk100);
    check("clear_pipe_rst_pulse", rst_pulses - rp0, 32'd1);
    check("clear_mode", {30'd0, mode}, 32'd0);
    busy_len = 2;
    cnt_model = cnt_model + 32'd1;
    push_dump();
    send_cmd(8'h53, a);
    wait_idle("post_clear_step_done");

    // randomized steps and runs
    for (int it = 0; it < 5; it++) begin
      randomize_mem();
      busy_len = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 0) begin
        cnt_model = cnt_model + 32'd1;
        push_dump();
        send_cmd(8'h53, a);
      end else begin
        len = $urandom_range(1, 40);
        send_cmd(8'h52, a);
        repeat (len) @(negedge clk100);
        send_cmd(8'h50, b);
        cnt_model = cnt_model + 32'(b - a);
        push_dump();
      end
      wait_idle("random_dump_done");
    end

    // asynchronous reset in the middle of a dump
    busy_len = 4;
    cnt_model = cnt_model + 32'd1;
    push_dump();
    send_cmd(8'h53, a);
    n = 0;
    while (exp_q.size() > 10 && n < 2000) begin
      @(negedge clk100);
      n++;
    end
    check("reset_mid_dump_reached", {31'd0, (n >= 2000)}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pipe_en", {31'd0, pipe_en}, 32'd0);
    check("async_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("async_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("async_rst_dbg_sel", {29'd0, dbg_sel}, 32'd0);
    check("async_rst_mode", {30'd0, mode}, 32'd0);
    check("async_rst_pipe_rst", {31'd0, pipe_rst}, 32'd0);
    exp_q.delete();
    cnt_model = 32'd0;
    st0 = starts;
    repeat (3) @(negedge clk100);
    rst_n = 1'b1;
    repeat (200) @(negedge clk100);
    check("no_tx_after_reset", starts - st0, 32'd0);
    check("mode_after_reset", {30'd0, mode}, 32'd0);
    cnt_model = cnt_model + 32'd1;
    push_dump();
    send_cmd(8'h53, a);
    wait_idle("post_reset_step_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
